// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between a processor core (master)
// and the backing-memory responder (slave).
interface data_mem_responder_if;
  logic        Req;
  logic        Write;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic        Ack;
  logic [31:0] ReadData;
  logic        Error;

  modport master (
    output Req, Write, Address, WriteData, ByteEn,
    input  Ack, ReadData, Error
  );

  modport slave (
    input  Req, Write, Address, WriteData, ByteEn,
    output Ack, ReadData, Error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Slow word-addressed data memory answering one load/store at a time with a
// fixed number of wait states, a one-cycle Ack pulse and an Error flag.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 CLK,
  input  logic                 Reset_L,
  data_mem_responder_if.slave  mem_bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  txn_wr_s;
  logic [31:0]           txn_addr_s;
  logic [31:0]           txn_wdata_s;
  logic [3:0]            txn_be_s;
  logic                  txn_err_s;
  logic [DEPTH_LOG2-1:0] txn_idx_s;
  logic                  commit_s;
  logic                  mem_we_s;

  logic [31:0]           mem_q [DEPTH];

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
  endfunction

  // With zero wait states the commit edge is also the sampling edge, so the
  // transaction fields come straight from the bus while still in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      txn_wr_s    = mem_bus.Write;
      txn_addr_s  = mem_bus.Address;
      txn_wdata_s = mem_bus.WriteData;
      txn_be_s    = mem_bus.ByteEn;
    end else begin
      txn_wr_s    = wr_q;
      txn_addr_s  = addr_q;
      txn_wdata_s = wdata_q;
      txn_be_s    = be_q;
    end
  end

  assign txn_err_s = addr_err(txn_addr_s);
  assign txn_idx_s = txn_addr_s[DEPTH_LOG2+1:2];
  assign commit_s  = (state_d == S_RESP);
  assign mem_we_s  = commit_s && txn_wr_s && !txn_err_s;

  // Next-state, request latching and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (mem_bus.Req) begin
          wr_d    = mem_bus.Write;
          addr_d  = mem_bus.Address;
          wdata_d = mem_bus.WriteData;
          be_d    = mem_bus.ByteEn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack_d   = commit_s;
    err_d   = commit_s && txn_err_s;
    if (commit_s && !txn_wr_s && !txn_err_s) begin
      rdata_d = mem_q[txn_idx_s];
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Control, latched request and registered response outputs.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM array: contents survive reset, only enabled lanes are written.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (txn_be_s[i]) begin
          mem_q[txn_idx_s][8*i +: 8] <= txn_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign mem_bus.Ack      = ack_q;
  assign mem_bus.ReadData = rdata_q;
  assign mem_bus.Error    = err_q;

endmodule
